// File: rtl/mapper.sv
// Request mapper: one-entry holding register that routes host requests to 16 bank queues
// and tags each dispatch with a wrapping sequence number.
package types_def;
   localparam int unsigned NBANKS = 16;
   localparam int unsigned BANK_W = 4;
   localparam int unsigned ADDR_W = 26;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned IDX_W  = 7;

   typedef struct packed {
      logic              req_type;
      logic [ADDR_W-1:0] address;
      logic [DATA_W-1:0] data;
   } request;
endpackage

module mapper
   import types_def::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  request              in_request,
   output logic                out_busy,
   input  logic                stop_reading,
   input  logic                stop_writing,
   output logic [NBANKS-1:0]   array_enable,
   output request              the_req,
   output logic [IDX_W-1:0]    out_index,
   input  logic [NBANKS-1:0]   in_busy,
   output logic                bank_out_valid
);

   logic              r_pend_v;
   request            r_pend_req;
   logic [IDX_W-1:0]  r_tag;

   logic [BANK_W-1:0] w_bank;
   logic              w_path_ok;
   logic              w_go;
   logic              w_accept;

   // Dispatch when the pending request's bank and read/write path are both free
   always_comb begin
      w_bank    = r_pend_req.address[BANK_W-1:0];
      w_path_ok = r_pend_req.req_type ? ~stop_writing : ~stop_reading;
      w_go      = r_pend_v & ~in_busy[w_bank] & w_path_ok;
      w_accept  = in_valid & (~r_pend_v | w_go);
   end

   // A dispatching entry frees the slot in the same edge a new request is captured
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend_v   <= 1'b0;
         r_pend_req <= '0;
         r_tag      <= '0;
      end else begin
         if (w_accept) begin
            r_pend_v   <= 1'b1;
            r_pend_req <= in_request;
         end else if (w_go) begin
            r_pend_v   <= 1'b0;
         end
         if (w_go)
            r_tag <= r_tag + IDX_W'(1);
      end
   end

   always_comb begin
      bank_out_valid = w_go;
      array_enable   = w_go ? (NBANKS'(1) << w_bank) : '0;
      the_req        = r_pend_req;
      out_index      = r_tag;
      out_busy       = r_pend_v & ~w_go;
   end

endmodule

// File: tb/tb_mapper.sv
// Self-checking bench for mapper: directed scenarios plus randomized traffic against a queue model.
module tb_mapper;
   import types_def::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   request            in_request;
   logic              out_busy;
   logic              stop_reading;
   logic              stop_writing;
   logic [NBANKS-1:0] array_enable;
   request            the_req;
   logic [IDX_W-1:0]  out_index;
   logic [NBANKS-1:0] in_busy;
   logic              bank_out_valid;

   int passed = 0;
   int total  = 0;

   mapper dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_request    (in_request),
      .out_busy      (out_busy),
      .stop_reading  (stop_reading),
      .stop_writing  (stop_writing),
      .array_enable  (array_enable),
      .the_req       (the_req),
      .out_index     (out_index),
      .in_busy       (in_busy),
      .bank_out_valid(bank_out_valid)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic t, input int addr, input int data,
                        input logic [NBANKS-1:0] busy, input logic sr, input logic sw);
      in_valid            = v;
      in_request.req_type = t;
      in_request.address  = ADDR_W'(addr);
      in_request.data     = DATA_W'(data);
      in_busy             = busy;
      stop_reading        = sr;
      stop_writing        = sw;
      #1;
   endtask

   task automatic idle(input logic [NBANKS-1:0] busy, input logic sr, input logic sw);
      drive(1'b0, 1'b0, 0, 0, busy, sr, sw);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      idle('0, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle('0, 1'b0, 1'b0);
      total += 5;
      if (out_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", out_busy); else passed++;
      if (bank_out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bank_out_valid); else passed++;
      if (array_enable !== 16'h0) $display("FAIL reset_en got=%h exp=0", array_enable); else passed++;
      if (the_req !== '0) $display("FAIL reset_req got=%h exp=0", the_req); else passed++;
      if (out_index !== 7'd0) $display("FAIL reset_idx got=%0d exp=0", out_index); else passed++;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single;
      do_reset();
      drive(1'b1, 1'b0, 0, 10, '0, 1'b0, 1'b0);
      tick();
      idle('0, 1'b0, 1'b0);
      total += 5;
      if (bank_out_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", bank_out_valid); else passed++;
      if (array_enable !== 16'h0001) $display("FAIL single_en got=%h exp=0001", array_enable); else passed++;
      if (the_req.data !== 16'd10) $display("FAIL single_data got=%0d exp=10", the_req.data); else passed++;
      if (out_index !== 7'd0) $display("FAIL single_idx got=%0d exp=0", out_index); else passed++;
      if (out_busy !== 1'b0) $display("FAIL single_busy got=%b exp=0", out_busy); else passed++;
      tick();
      total += 2;
      if (bank_out_valid !== 1'b0) $display("FAIL single_idle_valid got=%b exp=0", bank_out_valid); else passed++;
      if (array_enable !== 16'h0) $display("FAIL single_idle_en got=%h exp=0", array_enable); else passed++;
   endtask

   task automatic test_back_to_back;
      do_reset();
      drive(1'b1, 1'b0, 0, 11, '0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 15, 12, '0, 1'b0, 1'b0);
      total += 4;
      if (array_enable !== 16'h0001) $display("FAIL b2b_en0 got=%h exp=0001", array_enable); else passed++;
      if (the_req.data !== 16'd11) $display("FAIL b2b_data0 got=%0d exp=11", the_req.data); else passed++;
      if (out_index !== 7'd0) $display("FAIL b2b_idx0 got=%0d exp=0", out_index); else passed++;
      if (out_busy !== 1'b0) $display("FAIL b2b_busy0 got=%b exp=0", out_busy); else passed++;
      tick();
      idle('0, 1'b0, 1'b0);
      total += 4;
      if (array_enable !== 16'h8000) $display("FAIL b2b_en1 got=%h exp=8000", array_enable); else passed++;
      if (the_req.data !== 16'd12) $display("FAIL b2b_data1 got=%0d exp=12", the_req.data); else passed++;
      if (out_index !== 7'd1) $display("FAIL b2b_idx1 got=%0d exp=1", out_index); else passed++;
      if (out_busy !== 1'b0) $display("FAIL b2b_busy1 got=%b exp=0", out_busy); else passed++;
      tick();
      total += 1;
      if (bank_out_valid !== 1'b0) $display("FAIL b2b_idle got=%b exp=0", bank_out_valid); else passed++;
   endtask

   task automatic test_bank_busy;
      do_reset();
      drive(1'b1, 1'b1, 0, 20, 16'h0002, 1'b0, 1'b0);
      tick();
      idle(16'h0002, 1'b0, 1'b0);
      total += 2;
      if (bank_out_valid !== 1'b1) $display("FAIL otherbank_valid got=%b exp=1", bank_out_valid); else passed++;
      if (array_enable !== 16'h0001) $display("FAIL otherbank_en got=%h exp=0001", array_enable); else passed++;
      tick();
      drive(1'b1, 1'b1, 0, 21, 16'h0001, 1'b0, 1'b0);
      tick();
      idle(16'h0001, 1'b0, 1'b0);
      total += 4;
      if (bank_out_valid !== 1'b0) $display("FAIL held_valid got=%b exp=0", bank_out_valid); else passed++;
      if (out_busy !== 1'b1) $display("FAIL held_busy got=%b exp=1", out_busy); else passed++;
      if (array_enable !== 16'h0) $display("FAIL held_en got=%h exp=0", array_enable); else passed++;
      if (the_req.data !== 16'd21) $display("FAIL held_data got=%0d exp=21", the_req.data); else passed++;
      tick();
      idle('0, 1'b0, 1'b0);
      total += 4;
      if (bank_out_valid !== 1'b1) $display("FAIL release_valid got=%b exp=1", bank_out_valid); else passed++;
      if (array_enable !== 16'h0001) $display("FAIL release_en got=%h exp=0001", array_enable); else passed++;
      if (out_index !== 7'd1) $display("FAIL release_idx got=%0d exp=1", out_index); else passed++;
      if (out_busy !== 1'b0) $display("FAIL release_busy got=%b exp=0", out_busy); else passed++;
      tick();
      total += 1;
      if (bank_out_valid !== 1'b0) $display("FAIL release_idle got=%b exp=0", bank_out_valid); else passed++;
   endtask

   task automatic test_stop_paths;
      int n_disp;
      do_reset();
      drive(1'b1, 1'b1, 3, 30, '0, 1'b1, 1'b0);
      tick();
      idle('0, 1'b1, 1'b0);
      total += 2;
      if (bank_out_valid !== 1'b1) $display("FAIL sr_write_valid got=%b exp=1", bank_out_valid); else passed++;
      if (array_enable !== 16'h0008) $display("FAIL sr_write_en got=%h exp=0008", array_enable); else passed++;
      tick();
      drive(1'b1, 1'b1, 5, 31, '0, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 2; i++) begin
         idle('0, 1'b0, 1'b1);
         total += 2;
         if (bank_out_valid !== 1'b0) $display("FAIL sw_held_valid cyc=%0d got=%b exp=0", i, bank_out_valid); else passed++;
         if (out_busy !== 1'b1) $display("FAIL sw_held_busy cyc=%0d got=%b exp=1", i, out_busy); else passed++;
         tick();
      end
      n_disp = 0;
      idle('0, 1'b0, 1'b0);
      total += 2;
      if (array_enable !== 16'h0020) $display("FAIL sw_release_en got=%h exp=0020", array_enable); else passed++;
      if (out_index !== 7'd1) $display("FAIL sw_release_idx got=%0d exp=1", out_index); else passed++;
      for (int i = 0; i < 3; i++) begin
         if (bank_out_valid === 1'b1) n_disp++;
         tick();
      end
      total += 1;
      if (n_disp != 1) $display("FAIL sw_dispatch_count got=%0d exp=1", n_disp); else passed++;
   endtask

   task automatic test_drop;
      do_reset();
      drive(1'b1, 1'b1, 2, 15, '0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 2, 16, '0, 1'b0, 1'b1);
      total += 1;
      if (out_busy !== 1'b1) $display("FAIL drop_busy got=%b exp=1", out_busy); else passed++;
      tick();
      idle('0, 1'b0, 1'b0);
      total += 2;
      if (bank_out_valid !== 1'b1) $display("FAIL drop_valid got=%b exp=1", bank_out_valid); else passed++;
      if (the_req.data !== 16'd15) $display("FAIL drop_data got=%0d exp=15", the_req.data); else passed++;
      tick();
      total += 2;
      if (bank_out_valid !== 1'b0) $display("FAIL drop_second_valid got=%b exp=0", bank_out_valid); else passed++;
      if (the_req.data !== 16'd15) $display("FAIL drop_hold_data got=%0d exp=15", the_req.data); else passed++;
   endtask

   task automatic test_reset_stall;
      int n_disp;
      do_reset();
      drive(1'b1, 1'b0, 1, 40, 16'h0002, 1'b0, 1'b0);
      tick();
      idle(16'h0002, 1'b0, 1'b0);
      total += 1;
      if (out_busy !== 1'b1) $display("FAIL rststall_busy got=%b exp=1", out_busy); else passed++;
      rst = 1'b1;
      #1;
      total += 5;
      if (out_busy !== 1'b0) $display("FAIL rststall_rbusy got=%b exp=0", out_busy); else passed++;
      if (bank_out_valid !== 1'b0) $display("FAIL rststall_valid got=%b exp=0", bank_out_valid); else passed++;
      if (array_enable !== 16'h0) $display("FAIL rststall_en got=%h exp=0", array_enable); else passed++;
      if (the_req !== '0) $display("FAIL rststall_req got=%h exp=0", the_req); else passed++;
      if (out_index !== 7'd0) $display("FAIL rststall_idx got=%0d exp=0", out_index); else passed++;
      tick();
      rst = 1'b0;
      idle('0, 1'b0, 1'b0);
      n_disp = 0;
      for (int i = 0; i < 4; i++) begin
         if (bank_out_valid === 1'b1) n_disp++;
         tick();
      end
      total += 1;
      if (n_disp != 0) $display("FAIL rststall_after got=%0d exp=0 dispatches", n_disp); else passed++;
   endtask

   // Model: the holding slot as a queue of accepted-but-undispatched requests
   task automatic test_random;
      request q[$];
      request last_req;
      int     tag;
      request r;
      logic   go;
      logic [NBANKS-1:0] busy;
      int     bank;
      do_reset();
      last_req = '0;
      tag = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         busy = '0;
         for (int b = 0; b < int'(NBANKS); b++)
            if ($urandom_range(0, 7) == 0) busy[b] = 1'b1;
         r.req_type = 1'($urandom_range(0, 1));
         r.address  = ADDR_W'($urandom);
         r.data     = DATA_W'($urandom);
         drive(($urandom_range(0, 9) < 7), r.req_type, int'(r.address), int'(r.data), busy,
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
         go = 1'b0;
         bank = 0;
         if (q.size() != 0) begin
            bank = int'(q[0].address) % int'(NBANKS);
            go = !busy[bank] && (q[0].req_type ? !stop_writing : !stop_reading);
         end
         total += 5;
         if (bank_out_valid !== go)
            $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, bank_out_valid, go); else passed++;
         if (array_enable !== (go ? NBANKS'(1 << bank) : NBANKS'(0)))
            $display("FAIL rnd_en cyc=%0d got=%h bank=%0d go=%b", cyc, array_enable, bank, go); else passed++;
         if (out_busy !== (q.size() != 0 && !go))
            $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, out_busy, (q.size() != 0 && !go)); else passed++;
         if (the_req !== ((q.size() != 0) ? q[0] : last_req))
            $display("FAIL rnd_req cyc=%0d got=%h", cyc, the_req); else passed++;
         if (out_index !== IDX_W'(tag))
            $display("FAIL rnd_idx cyc=%0d got=%0d exp=%0d", cyc, out_index, tag % 128); else passed++;
         if (go) begin
            last_req = q.pop_front();
            tag = (tag + 1) % 128;
         end
         if (in_valid && q.size() == 0) q.push_back(in_request);
         tick();
      end
   endtask

   initial begin
      rst = 1'b0;
      idle('0, 1'b0, 1'b0);
      in_request = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_bank_busy();
      test_stop_paths();
      test_drop();
      test_reset_stall();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
